// File: rtl/dna_port_emu.sv
// Device DNA port responder: READ loads the ID, SHIFT streams it MSB first, sticky flags flag misuse.
// Latency: one register stage, every edge effect visible right after that edge; no backpressure.
module dna_port_emu #(
    parameter int                    DNA_LENGTH  = 96,
    parameter logic [DNA_LENGTH-1:0] DNA_VALUE   = 96'h0123456789ABCDEF00112233,
    parameter bit                    USE_PORT_ID = 1'b0,
    localparam int                   CW          = $clog2(DNA_LENGTH + 1) + 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_read,
    input  logic                  i_shift,
    input  logic                  i_din,
    input  logic [DNA_LENGTH-1:0] i_dna_id,
    output logic                  o_dout,
    output logic [CW-1:0]         o_shift_count,
    output logic                  o_loaded,
    output logic                  o_err_overrun,
    output logic                  o_err_unloaded,
    output logic                  o_err_collision
);

    localparam logic [CW-1:0] LEN_C = CW'(DNA_LENGTH);

    logic [DNA_LENGTH-1:0] r_sr;
    logic [CW-1:0]         r_cnt;
    logic                  r_loaded;
    logic                  r_err_overrun;
    logic                  r_err_unloaded;
    logic                  r_err_collision;
    logic [DNA_LENGTH-1:0] w_id;

    assign w_id = USE_PORT_ID ? i_dna_id : DNA_VALUE;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sr            <= '0;
            r_cnt           <= '0;
            r_loaded        <= 1'b0;
            r_err_overrun   <= 1'b0;
            r_err_unloaded  <= 1'b0;
            r_err_collision <= 1'b0;
        end else if (i_read) begin
            // A load wins over a simultaneous shift; the shift is only reported.
            r_sr     <= w_id;
            r_cnt    <= '0;
            r_loaded <= 1'b1;
            if (i_shift) begin
                r_err_collision <= 1'b1;
            end
        end else if (i_shift) begin
            r_sr <= {r_sr[DNA_LENGTH-2:0], i_din};
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_cnt >= LEN_C) begin
                r_err_overrun <= 1'b1;
            end
            if (!r_loaded) begin
                r_err_unloaded <= 1'b1;
            end
        end
    end

    assign o_dout          = r_sr[DNA_LENGTH-1];
    assign o_shift_count   = r_cnt;
    assign o_loaded        = r_loaded;
    assign o_err_overrun   = r_err_overrun;
    assign o_err_unloaded  = r_err_unloaded;
    assign o_err_collision = r_err_collision;

endmodule

// File: tb/tb_dna_port_emu.sv
// Bench for dna_port_emu: vector table, scoreboarded reference model, and port-ID / async-reset sequences.
module tb_dna_port_emu;

    localparam logic [95:0] ID = 96'h0123456789ABCDEF00112233;

    typedef struct packed {
        logic       dout;
        logic [7:0] cnt;
        logic       loaded;
        logic       ovr;
        logic       unl;
        logic       col;
    } exp_t;

    typedef struct {
        logic rd;
        logic sh;
        logic di;
        exp_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_read = 1'b0, a_shift = 1'b0, a_din = 1'b0;
    logic [95:0] a_dna_id = '0;
    logic        a_dout, a_loaded, a_ovr, a_unl, a_col;
    logic [7:0]  a_cnt;
    logic        b_read = 1'b0, b_shift = 1'b0, b_din = 1'b0;
    logic [95:0] b_dna_id = '0;
    logic        b_dout, b_loaded, b_ovr, b_unl, b_col;
    logic [7:0]  b_cnt;

    int checks   = 0;
    int failures = 0;
    exp_t sbq[$];

    logic [95:0] m_sr;
    logic [7:0]  m_cnt;
    logic        m_ld, m_ovr, m_unl, m_col;

    dna_port_emu u_a (
        .i_clock(clk), .i_reset(rst), .i_read(a_read), .i_shift(a_shift), .i_din(a_din),
        .i_dna_id(a_dna_id), .o_dout(a_dout), .o_shift_count(a_cnt), .o_loaded(a_loaded),
        .o_err_overrun(a_ovr), .o_err_unloaded(a_unl), .o_err_collision(a_col)
    );

    dna_port_emu #(.USE_PORT_ID(1'b1)) u_b (
        .i_clock(clk), .i_reset(rst), .i_read(b_read), .i_shift(b_shift), .i_din(b_din),
        .i_dna_id(b_dna_id), .o_dout(b_dout), .o_shift_count(b_cnt), .o_loaded(b_loaded),
        .o_err_overrun(b_ovr), .o_err_unloaded(b_unl), .o_err_collision(b_col)
    );

    always #5 clk = ~clk;

    function automatic exp_t a_out();
        exp_t r;
        r.dout = a_dout; r.cnt = a_cnt; r.loaded = a_loaded;
        r.ovr = a_ovr; r.unl = a_unl; r.col = a_col;
        return r;
    endfunction

    function automatic exp_t mk(logic dout, logic [7:0] cnt, logic ld, logic ovr, logic unl, logic col);
        exp_t r;
        r.dout = dout; r.cnt = cnt; r.loaded = ld; r.ovr = ovr; r.unl = unl; r.col = col;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic apply(input logic rd, input logic sh, input logic di, input exp_t e, input string nm);
        a_read = rd; a_shift = sh; a_din = di;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        chk(nm, 128'(a_out()), 128'(sbq.pop_front()));
    endtask

    task automatic step_model(input logic rd, input logic sh, input logic di, input string nm);
        if (rd) begin
            if (sh) m_col = 1'b1;
            m_sr = ID; m_cnt = 8'd0; m_ld = 1'b1;
        end else if (sh) begin
            if (m_cnt >= 8'd96) m_ovr = 1'b1;
            if (!m_ld) m_unl = 1'b1;
            m_sr = {m_sr[94:0], di};
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        apply(rd, sh, di, mk(m_sr[95], m_cnt, m_ld, m_ovr, m_unl, m_col), nm);
    endtask

    task automatic pulse_reset();
        a_read = 0; a_shift = 0; a_din = 0;
        b_read = 0; b_shift = 0; b_din = 0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        m_sr = '0; m_cnt = '0; m_ld = 0; m_ovr = 0; m_unl = 0; m_col = 0;
    endtask

    initial begin
        vec_t        tbl[16];
        logic [95:0] stream;

        #2 rst = 1'b1;
        #1 chk("reset_state", 128'(a_out()), 128'(mk(0, 0, 0, 0, 0, 0)));
        @(posedge clk);
        #1 rst = 1'b0;

        // Shift out of reset, collision load, then walk into the first set ID bit (bit 88).
        tbl[0] = '{0, 1, 0, mk(0, 1, 0, 0, 1, 0)};
        tbl[1] = '{0, 1, 1, mk(0, 2, 0, 0, 1, 0)};
        tbl[2] = '{0, 0, 0, mk(0, 2, 0, 0, 1, 0)};
        tbl[3] = '{1, 1, 0, mk(0, 0, 1, 0, 1, 1)};
        tbl[4] = '{0, 0, 0, mk(0, 0, 1, 0, 1, 1)};
        for (int i = 5; i <= 10; i++) tbl[i] = '{0, 1, 0, mk(0, 8'(i - 4), 1, 0, 1, 1)};
        tbl[11] = '{0, 1, 0, mk(1, 7, 1, 0, 1, 1)};
        tbl[12] = '{0, 1, 0, mk(0, 8, 1, 0, 1, 1)};
        tbl[13] = '{0, 1, 0, mk(0, 9, 1, 0, 1, 1)};
        tbl[14] = '{0, 1, 0, mk(1, 10, 1, 0, 1, 1)};
        tbl[15] = '{1, 0, 0, mk(0, 0, 1, 0, 1, 1)};
        for (int i = 0; i < 16; i++) apply(tbl[i].rd, tbl[i].sh, tbl[i].di, tbl[i].e, $sformatf("vec%0d", i));

        // Loopback readout of the built-in ID.
        pulse_reset();
        step_model(1, 0, 0, "t1_load");
        for (int k = 0; k < 96; k++) begin
            stream[95 - k] = a_dout;
            step_model(0, 1, a_dout, "t1_shift");
        end
        chk("t1_stream", 128'(stream), 128'(ID));
        chk("t1_end", 128'({a_cnt, a_ovr, a_unl, a_col}), 128'({8'd96, 3'b000}));

        // Overrun on the 97th shift survives a reload; counter saturates.
        step_model(1, 0, 0, "t3_load");
        for (int k = 0; k < 96; k++) step_model(0, 1, a_dout, "t3_shift");
        chk("t3_no_ovr_96", 128'(a_ovr), 128'(1'b0));
        step_model(0, 1, a_dout, "t3_shift97");
        chk("t3_ovr_97", 128'(a_ovr), 128'(1'b1));
        step_model(1, 0, 0, "t3_reload");
        chk("t3_reload", 128'({a_cnt, a_ovr}), 128'({8'd0, 1'b1}));
        for (int k = 0; k < 260; k++) step_model(0, 1, a_dout, "sat_shift");
        chk("sat_cnt", 128'(a_cnt), 128'(8'hFF));

        // Runtime ID: all-ones then 5, with dna_id changed while shifting.
        pulse_reset();
        for (int pass = 0; pass < 2; pass++) begin
            b_dna_id = (pass == 0) ? '1 : 96'h5;
            b_read = 1; b_shift = 0;
            @(posedge clk);
            #1;
            b_read = 0;
            b_dna_id = 96'hA5A5;
            for (int k = 0; k < 96; k++) begin
                stream[95 - k] = b_dout;
                b_shift = 1; b_din = b_dout;
                @(posedge clk);
                #1;
            end
            b_shift = 0;
            chk($sformatf("t6_stream%0d", pass), 128'(stream), (pass == 0) ? 128'({96{1'b1}}) : 128'h5);
            chk($sformatf("t6_flags%0d", pass), 128'({b_cnt, b_loaded, b_ovr, b_unl, b_col}),
                128'({8'd96, 4'b1000}));
        end

        // Asynchronous reset in the middle of a stream.
        b_dna_id = '1;
        b_read = 1;
        @(posedge clk);
        #1;
        b_read = 0; b_shift = 1; b_din = 1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
        end
        chk("t6_pre_reset", 128'({b_dout, b_cnt}), 128'({1'b1, 8'd10}));
        b_shift = 0;
        #2 rst = 1'b1;
        #1 chk("t6_async_rst", 128'({b_dout, b_cnt, b_loaded, b_ovr, b_unl, b_col}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        b_shift = 1; b_din = 0;
        @(posedge clk);
        #1;
        b_shift = 0;
        chk("t6_unloaded", 128'({b_dout, b_cnt, b_loaded, b_unl}), 128'({1'b0, 8'd1, 1'b0, 1'b1}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
